// File: rtl/pb_iteration_counter.sv
// Loop iteration counter: walks a signed iteration variable from lb toward ub by stride,
// with stall/abort control and a one-cycle done pulse. iv_out is zero outside RUN.
module pb_iteration_counter #(
  parameter int ITERATION_VARIABLE_WIDTH = 16
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       cfg_we,
  input  logic signed [ITERATION_VARIABLE_WIDTH-1:0] cfg_lb,
  input  logic signed [ITERATION_VARIABLE_WIDTH-1:0] cfg_ub,
  input  logic signed [ITERATION_VARIABLE_WIDTH-1:0] cfg_stride,
  input  logic                                       start,
  input  logic                                       stall,
  input  logic                                       abort,
  output logic signed [ITERATION_VARIABLE_WIDTH-1:0] iv_out,
  output logic                                       iv_valid,
  output logic                                       busy,
  output logic                                       done,
  output logic                                       cfg_err
);

  localparam int W = ITERATION_VARIABLE_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic signed [W-1:0]  r_cfg_lb;
  logic signed [W-1:0]  r_cfg_ub;
  logic signed [W-1:0]  r_cfg_stride;
  logic signed [W-1:0]  r_iv;

  // Step is evaluated one bit wider so overflow is detected rather than wrapped.
  logic signed [W:0]    w_next;
  logic signed [W:0]    w_ub_ext;
  logic                 w_overflow;
  logic                 w_past_ub;
  logic                 w_last;

  assign w_next     = {r_iv[W-1], r_iv} + {r_cfg_stride[W-1], r_cfg_stride};
  assign w_ub_ext   = {r_cfg_ub[W-1], r_cfg_ub};
  assign w_overflow = w_next[W] ^ w_next[W-1];
  assign w_past_ub  = r_cfg_stride[W-1] ? (w_next < w_ub_ext) : (w_next > w_ub_ext);
  assign w_last     = w_overflow | w_past_ub;

  logic w_stride_zero;
  logic w_stride_pos;
  logic w_stride_neg;
  logic w_cfg_illegal;

  assign w_stride_zero = (cfg_stride == '0);
  assign w_stride_neg  = cfg_stride[W-1];
  assign w_stride_pos  = !w_stride_zero && !w_stride_neg;
  assign w_cfg_illegal = w_stride_zero
                       | (w_stride_pos && (cfg_lb > cfg_ub))
                       | (w_stride_neg && (cfg_lb < cfg_ub));

  // NOTE: all state and outputs are updated with non-blocking assignments in one
  // clocked block, so every output is a register and reset clears them without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cfg_lb     <= '0;
      r_cfg_ub     <= '0;
      r_cfg_stride <= '0;
      r_iv         <= '0;
      iv_out       <= '0;
      iv_valid     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cfg_err      <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          done <= 1'b0;
          if (cfg_we) begin
            r_cfg_lb     <= cfg_lb;
            r_cfg_ub     <= cfg_ub;
            r_cfg_stride <= cfg_stride;
            cfg_err      <= w_cfg_illegal;
          end
          // Start sees the configuration already registered, never the one arriving now.
          if (start && !abort && !cfg_err) begin
            r_state  <= ST_RUN;
            r_iv     <= r_cfg_lb;
            iv_out   <= r_cfg_lb;
            iv_valid <= 1'b1;
            busy     <= 1'b1;
          end
        end

        ST_RUN: begin
          if (abort) begin
            r_state  <= ST_IDLE;
            r_iv     <= '0;
            iv_out   <= '0;
            iv_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
          end else if (!stall) begin
            if (w_last) begin
              r_state  <= ST_DONE;
              r_iv     <= '0;
              iv_out   <= '0;
              iv_valid <= 1'b0;
              done     <= 1'b1;
            end else begin
              r_iv   <= w_next[W-1:0];
              iv_out <= w_next[W-1:0];
            end
          end
        end

        ST_DONE: begin
          // The done pulse already on the output completes regardless of abort.
          r_state  <= ST_IDLE;
          iv_out   <= '0;
          iv_valid <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end

        default: begin
          r_state  <= ST_IDLE;
          r_iv     <= '0;
          iv_out   <= '0;
          iv_valid <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pb_iteration_counter.sv
// Table-driven bench for pb_iteration_counter: one row per clock cycle with hand-computed
// expected outputs, plus sequences for iteration counting and asynchronous reset.
module tb_pb_iteration_counter;

  localparam int W = 16;

  logic                clk;
  logic                rst_n;
  logic                cfg_we;
  logic signed [W-1:0] cfg_lb;
  logic signed [W-1:0] cfg_ub;
  logic signed [W-1:0] cfg_stride;
  logic                start;
  logic                stall;
  logic                abort;
  logic signed [W-1:0] iv_out;
  logic                iv_valid;
  logic                busy;
  logic                done;
  logic                cfg_err;

  pb_iteration_counter #(.ITERATION_VARIABLE_WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_lb     (cfg_lb),
    .cfg_ub     (cfg_ub),
    .cfg_stride (cfg_stride),
    .start      (start),
    .stall      (stall),
    .abort      (abort),
    .iv_out     (iv_out),
    .iv_valid   (iv_valid),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic                we;
    logic signed [W-1:0] lb;
    logic signed [W-1:0] ub;
    logic signed [W-1:0] stride;
    logic                start;
    logic                stall;
    logic                abort;
    int                  exp_iv;
    int                  exp_valid;
    int                  exp_busy;
    int                  exp_done;
    int                  exp_err;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input int we, input int lb, input int ub, input int st,
                     input int s, input int sl, input int ab,
                     input int iv, input int v, input int b, input int d, input int e);
    vec_t r;
    r.we = we[0]; r.lb = 16'(lb); r.ub = 16'(ub); r.stride = 16'(st);
    r.start = s[0]; r.stall = sl[0]; r.abort = ab[0];
    r.exp_iv = iv; r.exp_valid = v; r.exp_busy = b; r.exp_done = d; r.exp_err = e;
    vq.push_back(r);
  endtask

  task automatic nop(input int iv, input int v, input int b, input int d, input int e);
    add(0, 0, 0, 0, 0, 0, 0, iv, v, b, d, e);
  endtask

  task automatic idle_inputs();
    cfg_we = 1'b0; cfg_lb = '0; cfg_ub = '0; cfg_stride = '0;
    start = 1'b0; stall = 1'b0; abort = 1'b0;
  endtask

  task automatic check_outputs(input string tag, input int iv, input int v,
                               input int b, input int d, input int e);
    check({tag, " iv_out"},   int'(iv_out),   iv);
    check({tag, " iv_valid"}, int'(iv_valid), v);
    check({tag, " busy"},     int'(busy),     b);
    check({tag, " done"},     int'(done),     d);
    check({tag, " cfg_err"},  int'(cfg_err),  e);
  endtask

  initial begin
    int  n_iter;
    bit  seen_done;

    // Unconfigured start, then basic up-count 0..4
    add(0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 1);
    add(1, 0, 4, 1, 0, 0, 0,   0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,   0, 1, 1, 0, 0);
    nop(1, 1, 1, 0, 0); nop(2, 1, 1, 0, 0); nop(3, 1, 1, 0, 0); nop(4, 1, 1, 0, 0);
    nop(0, 0, 1, 1, 0); nop(0, 0, 0, 0, 0);
    // Negative stride with a two-cycle stall at iv=7
    add(1, 10, 1, -3, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,   10, 1, 1, 0, 0);
    nop(7, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0,   7, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0,   7, 1, 1, 0, 0);
    nop(4, 1, 1, 0, 0); nop(1, 1, 1, 0, 0); nop(0, 0, 1, 1, 0); nop(0, 0, 0, 0, 0);
    // Illegal configurations
    add(1, 0, 4, 0, 0, 0, 0,   0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 1);
    add(1, 5, 2, 2, 0, 0, 0,   0, 0, 0, 0, 1);
    add(1, -5, 5, -1, 0, 0, 0, 0, 0, 0, 0, 1);
    // lb == ub: exactly one iteration
    add(1, 3, 3, -1, 0, 0, 0,  0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,   3, 1, 1, 0, 0);
    nop(0, 0, 1, 1, 0); nop(0, 0, 0, 0, 0);
    // Stride that does not land on ub
    add(1, 0, 10, 4, 0, 0, 0,  0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,   0, 1, 1, 0, 0);
    nop(4, 1, 1, 0, 0); nop(8, 1, 1, 0, 0); nop(0, 0, 1, 1, 0); nop(0, 0, 0, 0, 0);
    // Positive and negative overflow terminate without wrapping
    add(1, 32760, 32767, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,   32760, 1, 1, 0, 0);
    nop(32765, 1, 1, 0, 0); nop(0, 0, 1, 1, 0); nop(0, 0, 0, 0, 0);
    add(1, -32760, -32768, -5, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,   -32760, 1, 1, 0, 0);
    nop(-32765, 1, 1, 0, 0); nop(0, 0, 1, 1, 0); nop(0, 0, 0, 0, 0);
    // Abort (with stall) at iv=2 of 0..9; done never pulses
    add(1, 0, 9, 1, 0, 0, 0,   0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,   0, 1, 1, 0, 0);
    nop(1, 1, 1, 0, 0); nop(2, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0);
    nop(0, 0, 0, 0, 0);
    // Start with abort stays idle
    add(0, 0, 0, 0, 1, 0, 1,   0, 0, 0, 0, 0);
    // cfg_we during RUN is ignored; restart uses old bounds
    add(0, 0, 0, 0, 1, 0, 0,   0, 1, 1, 0, 0);
    add(1, 100, 50, 7, 0, 0, 0, 1, 1, 1, 0, 0);
    nop(2, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,   0, 1, 1, 0, 0);
    nop(1, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0);
    // Abort in the DONE cycle: pulse already present completes, then idle
    add(1, 0, 1, 1, 0, 0, 0,   0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,   0, 1, 1, 0, 0);
    nop(1, 1, 1, 0, 0); nop(0, 0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0);
    nop(0, 0, 0, 0, 0);

    // Reset state
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_outputs("reset", 0, 0, 0, 0, 1);
    @(negedge clk) rst_n = 1'b1;

    foreach (vq[i]) begin
      cfg_we = vq[i].we; cfg_lb = vq[i].lb; cfg_ub = vq[i].ub; cfg_stride = vq[i].stride;
      start = vq[i].start; stall = vq[i].stall; abort = vq[i].abort;
      @(posedge clk);
      #1 check_outputs($sformatf("row%0d", i), vq[i].exp_iv, vq[i].exp_valid,
                       vq[i].exp_busy, vq[i].exp_done, vq[i].exp_err);
      @(negedge clk);
    end

    // Iteration count -7..20 by 6 with a stall: floor(27/6)+1 = 5 emitted iterations
    idle_inputs();
    cfg_we = 1'b1; cfg_lb = -16'sd7; cfg_ub = 16'sd20; cfg_stride = 16'sd6;
    @(negedge clk);
    idle_inputs();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_iter = 0;
    seen_done = 1'b0;
    for (int c = 0; c < 50; c++) begin
      stall = (c == 2 || c == 3);
      if (done) begin
        seen_done = 1'b1;
        break;
      end
      if (iv_valid && !stall) n_iter++;
      @(negedge clk);
    end
    stall = 1'b0;
    check("count done_seen", int'(seen_done), 1);
    check("count iterations", n_iter, 5);

    // Asynchronous reset mid-RUN
    @(negedge clk);
    cfg_we = 1'b1; cfg_lb = 16'sd0; cfg_ub = 16'sd9; cfg_stride = 16'sd1;
    @(negedge clk);
    cfg_we = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_reset iv_out", int'(iv_out), 2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_outputs("async_reset", 0, 0, 0, 0, 1);
    @(negedge clk) rst_n = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 check_outputs("post_reset_start", 0, 0, 0, 0, 1);
    @(negedge clk) start = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
